// File: rtl/seq_detect_pkg.sv
`default_nettype none
// ============================================================================
// Module   : seq_detect_pkg
// Brief    : Shared types and defaults for the multi-pattern sequence detector
// Revision : 1.0 - initial release
// ============================================================================

package seq_detect_pkg;

    localparam int DEF_PAT_W   = 8;
    localparam int DEF_NUM_PAT = 2;
    localparam int DEF_CNT_W   = 8;

    // Slot storage is sized for the largest supported pattern (PAT_W <= 32).
    localparam int PAT_W_MAX = 32;
    localparam int LEN_W_MAX = 6;

    typedef enum logic {
        OVL_OFF = 1'b0,
        OVL_ON  = 1'b1
    } ovl_mode_e;

    typedef struct packed {
        logic [PAT_W_MAX-1:0] pat;
        logic [LEN_W_MAX-1:0] len;
    } pat_slot_t;

endpackage

`default_nettype wire

// File: rtl/seq_pat_cmp.sv
`default_nettype none
// ============================================================================
// Module   : seq_pat_cmp
// Brief    : Combinational compare of the next history against one pattern slot
// Revision : 1.0 - initial release
// ============================================================================

module seq_pat_cmp
    import seq_detect_pkg::*;
#(
    parameter  int PAT_W = DEF_PAT_W,
    localparam int LW    = $clog2(PAT_W + 1)
) (
    input  logic [PAT_W-1:0] hist_nxt,
    input  logic [LW-1:0]    fill_nxt,
    input  pat_slot_t        slot,
    output logic             hit
);

    logic [PAT_W_MAX-1:0] hist_ext;
    logic [PAT_W_MAX-1:0] len_mask;
    logic [LEN_W_MAX-1:0] fill_ext;
    logic                 len_ok;

    always_comb begin
        hist_ext            = '0;
        hist_ext[PAT_W-1:0] = hist_nxt;
        fill_ext            = LEN_W_MAX'(fill_nxt);
        len_mask            = '0;
        for (int b = 0; b < PAT_W_MAX; b++) begin
            len_mask[b] = (b < int'(slot.len));
        end
        // Zero or over-long lengths mark the slot as disabled.
        len_ok = (slot.len != '0) && (slot.len <= LEN_W_MAX'(PAT_W));
        hit    = len_ok && (fill_ext >= slot.len) &&
                 (((hist_ext ^ slot.pat) & len_mask) == '0);
    end

endmodule

`default_nettype wire

// File: rtl/seq_detect_multi.sv
`default_nettype none
// ============================================================================
// Module   : seq_detect_multi
// Brief    : Runtime-programmable multi-pattern serial bit detector.
//            SEQDET_CNT_EN builds the saturating match event counter.
// Revision : 1.0 - initial release
// ============================================================================

module seq_detect_multi
    import seq_detect_pkg::*;
#(
    parameter  int PAT_W   = DEF_PAT_W,
    parameter  int NUM_PAT = DEF_NUM_PAT,
    parameter  int CNT_W   = DEF_CNT_W,
    localparam int LW      = $clog2(PAT_W + 1),
    localparam int SEL_W   = (NUM_PAT > 1) ? $clog2(NUM_PAT) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clr,
    input  logic               in_valid,
    input  logic               i,
    input  logic               ovl,
    input  logic               cfg_we,
    input  logic [SEL_W-1:0]   cfg_sel,
    input  logic [PAT_W-1:0]   cfg_pat,
    input  logic [LW-1:0]      cfg_len,
    output logic               match,
    output logic [NUM_PAT-1:0] match_id,
    output logic [CNT_W-1:0]   match_cnt
);

    logic [PAT_W-1:0]   hist_q, hist_d, hist_nxt;
    logic [LW-1:0]      fill_q, fill_d, fill_nxt;
    pat_slot_t          slot_q [NUM_PAT];
    pat_slot_t          slot_d [NUM_PAT];
    logic [NUM_PAT-1:0] hit;
    logic [NUM_PAT-1:0] match_id_q, match_id_d;
    logic               match_q, match_d;
    logic               accept;

    assign accept   = in_valid & ~cfg_we & ~clr;
    assign hist_nxt = {hist_q[PAT_W-2:0], i};
    assign fill_nxt = (fill_q == LW'(PAT_W)) ? fill_q : fill_q + LW'(1);

    generate
        for (genvar p = 0; p < NUM_PAT; p++) begin : g_slot
            seq_pat_cmp #(.PAT_W(PAT_W)) u_cmp (
                .hist_nxt (hist_nxt),
                .fill_nxt (fill_nxt),
                .slot     (slot_q[p]),
                .hit      (hit[p])
            );
        end
    endgenerate

    always_comb begin
        hist_d = hist_q;
        fill_d = fill_q;
        if (clr) begin
            hist_d = '0;
            fill_d = '0;
        end else if (cfg_we) begin
            fill_d = '0;
        end else if (in_valid) begin
            hist_d = hist_nxt;
            // Non-overlapping mode restarts the fill on any hit.
            fill_d = ((ovl_mode_e'(ovl) == OVL_OFF) && (|hit)) ? '0 : fill_nxt;
        end
    end

    always_comb begin
        slot_d = slot_q;
        for (int p = 0; p < NUM_PAT; p++) begin
            if (cfg_we && (cfg_sel == SEL_W'(p))) begin
                slot_d[p].pat            = '0;
                slot_d[p].pat[PAT_W-1:0] = cfg_pat;
                slot_d[p].len            = LEN_W_MAX'(cfg_len);
            end
        end
    end

    always_comb begin
        match_id_d = accept ? hit : '0;
        match_d    = |match_id_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hist_q     <= '0;
            fill_q     <= '0;
            match_q    <= 1'b0;
            match_id_q <= '0;
            for (int p = 0; p < NUM_PAT; p++) begin
                slot_q[p] <= '0;
            end
        end else begin
            hist_q     <= hist_d;
            fill_q     <= fill_d;
            match_q    <= match_d;
            match_id_q <= match_id_d;
            slot_q     <= slot_d;
        end
    end

    assign match    = match_q;
    assign match_id = match_id_q;

`ifdef SEQDET_CNT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (match_d && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign match_cnt = cnt_q;
`else
    assign match_cnt = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_seq_detect_multi.sv
`default_nettype none
// ============================================================================
// Module   : tb_seq_detect_multi
// Brief    : Directed self-checking bench for seq_detect_multi (CNT_W=8 and 2)
// Revision : 1.0 - initial release
// ============================================================================

module tb_seq_detect_multi;

    logic       clk = 1'b0;
    logic       rst, clr, in_valid, i, ovl, cfg_we;
    logic [0:0] cfg_sel;
    logic [7:0] cfg_pat;
    logic [3:0] cfg_len;

    logic       match, match_s;
    logic [1:0] match_id, match_id_s;
    logic [7:0] match_cnt;
    logic [1:0] match_cnt_s;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    seq_detect_multi #(.PAT_W(8), .NUM_PAT(2), .CNT_W(8)) u_dut (
        .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .i(i), .ovl(ovl),
        .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_pat(cfg_pat), .cfg_len(cfg_len),
        .match(match), .match_id(match_id), .match_cnt(match_cnt)
    );

    // Same stimulus, narrow counter to exercise saturation.
    seq_detect_multi #(.PAT_W(8), .NUM_PAT(2), .CNT_W(2)) u_dut_sat (
        .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .i(i), .ovl(ovl),
        .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_pat(cfg_pat), .cfg_len(cfg_len),
        .match(match_s), .match_id(match_id_s), .match_cnt(match_cnt_s)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [31:0] cnt_exp(input int n, input int w);
        int mx;
        mx = (1 << w) - 1;
`ifdef SEQDET_CNT_EN
        return (n > mx) ? mx : n;
`else
        return (mx < 0) ? n : 0;
`endif
    endfunction

    task automatic send_bit(input logic b);
        in_valid = 1'b1;
        i        = b;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic cfg_write(input logic s, input logic [7:0] p, input logic [3:0] l);
        cfg_we  = 1'b1;
        cfg_sel = s;
        cfg_pat = p;
        cfg_len = l;
        @(posedge clk); #1;
        cfg_we  = 1'b0;
    endtask

    task automatic do_clr;
        clr = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
    endtask

    // bits[k] is the k-th bit sent; exp[2k+:2] is the match_id expected after it.
    task automatic run_stream(input string tag, input int n, input logic [7:0] bits,
                              input logic [15:0] exp);
        logic [1:0] e;
        for (int k = 0; k < n; k++) begin
            e = exp[2*k +: 2];
            send_bit(bits[k]);
            check_eq($sformatf("%s_id%0d", tag, k + 1), 32'(match_id), 32'(e));
            check_eq($sformatf("%s_m%0d", tag, k + 1), 32'(match), 32'(|e));
        end
    endtask

    initial begin
        rst = 1'b1; clr = 1'b0; in_valid = 1'b0; i = 1'b0; ovl = 1'b1;
        cfg_we = 1'b0; cfg_sel = '0; cfg_pat = '0; cfg_len = '0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_match", 32'(match), 32'd0);
        check_eq("rst_id", 32'(match_id), 32'd0);
        check_eq("rst_cnt", 32'(match_cnt), 32'd0);
        check_eq("rst_cnt_sat", 32'(match_cnt_s), 32'd0);
        rst = 1'b0;

        cfg_write(1'b0, 8'b111, 4'd3);
        cfg_write(1'b1, 8'b101, 4'd3);
        ovl = 1'b1;
        run_stream("ovl_111", 4, 8'b0000_1111,
                   {2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 2'b01, 2'b00, 2'b00});
        @(posedge clk); #1;
        check_eq("ovl_111_idle", 32'(match), 32'd0);
        check_eq("ovl_111_cnt", 32'(match_cnt), cnt_exp(2, 8));
        check_eq("ovl_111_cnt_sat", 32'(match_cnt_s), cnt_exp(2, 2));

        do_clr;
        check_eq("clr_cnt", 32'(match_cnt), 32'd0);
        run_stream("ovl_101", 5, 8'b0001_0101,
                   {2'b00, 2'b00, 2'b00, 2'b10, 2'b00, 2'b10, 2'b00, 2'b00});

        do_clr;
        ovl = 1'b0;
        run_stream("novl_101", 5, 8'b0001_0101,
                   {2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b10, 2'b00, 2'b00});

        do_clr;
        run_stream("novl_111", 6, 8'b0011_1111,
                   {2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00});
        check_eq("novl_111_cnt", 32'(match_cnt), cnt_exp(2, 8));

        cfg_write(1'b0, 8'b101, 4'd3);
        cfg_write(1'b1, 8'b01, 4'd2);
        do_clr;
        ovl = 1'b1;
        run_stream("dual", 3, 8'b0000_0101,
                   {2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b11, 2'b00, 2'b00});
        @(posedge clk); #1;
        check_eq("dual_pulse", 32'(match), 32'd0);
        check_eq("dual_cnt", 32'(match_cnt), cnt_exp(1, 8));

        // Reset in the middle of a partial 111.
        cfg_write(1'b0, 8'b111, 4'd3);
        run_stream("pre_rst", 2, 8'b0000_0011, 16'h0000);
        rst = 1'b1; #3; rst = 1'b0;
        @(posedge clk); #1;
        check_eq("mid_rst_cnt", 32'(match_cnt), 32'd0);
        cfg_write(1'b0, 8'b111, 4'd3);
        cfg_write(1'b1, 8'b00, 4'd2);
        run_stream("post_rst", 3, 8'b0000_0111,
                   {2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00});

        // Config write concurrent with a valid bit mid-pattern.
        do_clr;
        run_stream("pre_cfg", 2, 8'b0000_0011, 16'h0000);
        cfg_we = 1'b1; cfg_sel = 1'b1; cfg_pat = 8'b00; cfg_len = 4'd2;
        in_valid = 1'b1; i = 1'b1;
        @(posedge clk); #1;
        cfg_we = 1'b0; in_valid = 1'b0;
        check_eq("cfg_bit_m", 32'(match), 32'd0);
        run_stream("post_cfg", 3, 8'b0000_0111,
                   {2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00});

        do_clr;
        run_stream("sat", 7, 8'b0111_1111,
                   {2'b00, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b00, 2'b00});
        check_eq("sat_cnt", 32'(match_cnt), cnt_exp(5, 8));
        check_eq("sat_cnt_sat", 32'(match_cnt_s), cnt_exp(5, 2));
        do_clr;
        check_eq("sat_clr", 32'(match_cnt), 32'd0);
        check_eq("sat_clr_sat", 32'(match_cnt_s), 32'd0);

        // Length above PAT_W disables; length equal to PAT_W is the longest legal.
        cfg_write(1'b0, 8'hFF, 4'd9);
        run_stream("len9", 8, 8'hFF, 16'h0000);
        cfg_write(1'b0, 8'hFF, 4'd8);
        run_stream("len8", 8, 8'hFF,
                   {2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00});

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/seq_detect_multi.md
# seq_detect_multi

Parametrised, runtime-programmable serial bit-pattern detector, the general successor to the fixed 111/101 detectors. It holds NUM_PAT patterns of up to PAT_W bits each, loaded through a configuration write port. It compares every accepted input bit against all patterns in parallel and reports which patterns completed, in overlapping or non-overlapping mode. It sits on a serial bit stream in the protocol front end and optionally counts match events.

## Interface
- PAT_W, 8, maximum pattern length in bits (>=2)
- NUM_PAT, 2, number of independently programmable patterns (>=1)
- CNT_W, 8, width of the match event counter
- LW, $clog2(PAT_W+1), derived width of length fields (localparam)

- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- clr  in  1  synchronous clear of history, fill level and counter; config untouched
- in_valid  in  1  input bit qualifier
- i  in  1  serial data bit, sampled when in_valid=1
- ovl  in  1  mode: 1 = overlapping, 0 = non-overlapping
- cfg_we  in  1  pattern write strobe
- cfg_sel  in  $clog2(NUM_PAT) (min 1)  pattern slot index
- cfg_pat  in  PAT_W  pattern bits; bit len-1 is received first, bit 0 last
- cfg_len  in  LW  pattern length; 0 or >PAT_W disables the slot
- match  out  1  registered pulse: at least one pattern completed
- match_id  out  NUM_PAT  registered one-hot-per-slot hit vector
- match_cnt  out  CNT_W  saturating match event count

## Operation
- History register hist[PAT_W-1:0], with hist[0] = newest bit. Fill counter fill, 0..PAT_W, saturating.
- Accepted bit (in_valid=1, cfg_we=0, clr=0): hist_nxt = {hist[PAT_W-2:0], i}; fill_nxt = min(fill+1, PAT_W).
- Slot p hits when 1 <= len_p <= PAT_W, fill_nxt >= len_p, and hist_nxt[len_p-1:0] == pat_p[len_p-1:0]. Evaluation uses next-state values, so the completing bit counts.
- match_id[p] <= hit_p; match <= |hit. Both are 0 on any cycle with no accepted bit.
- Overlapping mode (ovl=1): history and fill continue after a hit. Example: 1,1,1,1 against 111 gives two hits.
- Non-overlapping mode (ovl=0): any hit forces fill <= 0 on the same edge, so the next match needs len fresh bits.
- Simultaneous hits on several slots are all reported. In non-overlapping mode, one shared fill clear applies.
- cfg_we=1: slot cfg_sel is loaded with cfg_pat/cfg_len and fill <= 0. A concurrent in_valid bit is discarded. The new pattern is effective from the next accepted bit.
- clr has priority over cfg history effects and over in_valid. It zeroes hist, fill, match, match_id and match_cnt. A concurrent cfg write still loads the slot.
- ovl may change at any time and applies to the next accepted bit.
- match_cnt increments by 1 per cycle with match_nxt=1, and saturates at 2^CNT_W-1.

## Timing
- Reset values: hist=0, fill=0, match=0, match_id=0, match_cnt=0, all slots len=0 (disabled), pat=0.
- Latency: the completing bit is accepted on edge N, and match/match_id are high during cycle N+1 only. This is Moore-style, one cycle after the last bit.
- Back-to-back hits on consecutive accepted bits produce a continuously high match.
- Reset asserted mid-pattern aborts the partial match immediately. After release, a full-length sequence is required.
- No backpressure; every in_valid bit is consumed unless cfg_we or clr is active.

## Configuration
- SEQDET_CNT_EN: when defined, the match_cnt saturating counter is built.
- When undefined, match_cnt is tied to 0 and no counter flops are inferred. All other behaviour is identical.

## Structure
- Package seq_detect_pkg holds the mode enum (OVL_OFF, OVL_ON), the default parameter constants and the pattern-slot struct {pat, len}.
- Sub-module seq_pat_cmp: one instance per slot via generate. It is combinational: given hist_nxt, fill_nxt, pat and len, it produces hit.
- The top level owns the history, fill, config registers, output registers and counter.

## Test plan
- Slot0=111/3, slot1=101/3, ovl=1, stream 1,1,1,1 -> match_id=01 in the cycles after bits 3 and 4; no slot1 hit.
- Same config, ovl=1, stream 1,0,1,0,1 -> match_id=10 after bits 3 and 5. With ovl=0, only after bit 3; bit 5 gives no hit because fill was cleared.
- ovl=0, slot0=111/3, six 1s -> hits after bits 3 and 6 only; match_cnt=2 (SEQDET_CNT_EN defined).
- Slot0=101/3, slot1=01/2, stream 1,0,1 -> match_id=11, single match pulse, match_cnt +1.
- Stream 1,1, rst pulse, then 1 -> no hit. cfg_we issued together with in_valid mid-pattern -> bit discarded, fill=0, no spurious hit.
- CNT_W=2, 5 hits -> match_cnt sticks at 3. clr -> match_cnt=0. Without the macro, match_cnt stays 0 throughout.
